// File: rtl/atb_assoc.sv
// ---------------------------------------------------------------------------
// atb_assoc -- set-associative alternate target buffer.
//
// Each set holds WAYS entries of {valid, full PC tag, target PC}.  A lookup
// (is_branch_i) compares pc_i against every way of the indexed set.  The
// result is registered, so it appears on atb_valid_o/atb_tgt_pc_o after the
// edge that samples the request.  Retiring branches update a matching entry
// in place, or else allocate the lowest invalid way.  When the set is full,
// they replace the way at a per-set round-robin victim pointer.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : asynchronous active-high reset
//   is_branch_i      : lookup request this cycle
//   pc_i             : lookup PC
//   retire_valid_i   : write request this cycle
//   retire_pc_i      : PC of the retiring branch
//   retire_tgt_pc_i  : resolved target of the retiring branch
//   flush_i          : invalidate every entry and victim pointer
//   atb_valid_o      : registered lookup hit
//   atb_tgt_pc_o     : registered hit target, zero on a miss
//   hit_cnt_o        : saturating count of lookup hits
//   miss_cnt_o       : saturating count of lookup misses
// ---------------------------------------------------------------------------
module atb_assoc #(
   parameter int SETS = 64,
   parameter int WAYS = 4,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            is_branch_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic            retire_valid_i,
   input  logic [PC_W-1:0] retire_pc_i,
   input  logic [PC_W-1:0] retire_tgt_pc_i,
   input  logic            flush_i,
   output logic            atb_valid_o,
   output logic [PC_W-1:0] atb_tgt_pc_o,
   output logic [15:0]     hit_cnt_o,
   output logic [15:0]     miss_cnt_o
);

   localparam int IDX_W = $clog2(SETS);
   // A one-way buffer needs no victim pointer.  The pointer is kept 1 bit
   // wide and held at zero so the declarations stay legal.
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   // Per-way state: valid bits and victim pointers need reset.
   // Tags and targets do not, because a way is never read while invalid.
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];
   logic [PTR_W-1:0] vptr_q  [SETS];
   logic [PTR_W-1:0] vptr_d  [SETS];
   logic [PC_W-1:0]  tag_mem [SETS][WAYS];
   logic [PC_W-1:0]  tgt_mem [SETS][WAYS];

   logic            out_valid_q, out_valid_d;
   logic [PC_W-1:0] out_tgt_q,   out_tgt_d;
   logic [15:0]     hit_cnt_q,   hit_cnt_d;
   logic [15:0]     miss_cnt_q,  miss_cnt_d;

   logic [IDX_W-1:0] lk_idx, rt_idx;
   logic [WAYS-1:0]  lk_match, rt_match;
   logic             lk_hit, rt_hit;
   logic [PC_W-1:0]  lk_tgt;
   logic             rt_free_any;
   logic [PTR_W-1:0] rt_free_way, rt_hit_way, rt_way;
   logic             rt_we, rt_advance;

   assign lk_idx = pc_i[IDX_W-1:0];
   assign rt_idx = retire_pc_i[IDX_W-1:0];

   // Tag compare on the pre-write contents of both indexed sets.  A
   // same-cycle lookup therefore never observes the retire it races with.
   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_match
         assign lk_match[gi] = valid_q[lk_idx][gi] && (tag_mem[lk_idx][gi] == pc_i);
         assign rt_match[gi] = valid_q[rt_idx][gi] && (tag_mem[rt_idx][gi] == retire_pc_i);
      end
   endgenerate

   assign lk_hit = |lk_match;
   assign rt_hit = |rt_match;

   // At most one way can match, so OR-ing the masked targets selects it.
   always_comb begin
      lk_tgt = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_match[w]) lk_tgt = lk_tgt | tgt_mem[lk_idx][w];
      end
   end

   // Retire way selection.  The loop runs from the top way down, so the
   // last assignment wins and selects the lowest-numbered invalid way.
   always_comb begin
      rt_free_any = 1'b0;
      rt_free_way = '0;
      rt_hit_way  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[rt_idx][w]) begin
            rt_free_any = 1'b1;
            rt_free_way = PTR_W'(w);
         end
         if (rt_match[w]) rt_hit_way = PTR_W'(w);
      end
      if (rt_hit)           rt_way = rt_hit_way;
      else if (rt_free_any) rt_way = rt_free_way;
      else                  rt_way = vptr_q[rt_idx];
   end

   // Flush wins over a concurrent retire.
   assign rt_we      = retire_valid_i && !flush_i;
   assign rt_advance = rt_we && !rt_hit && !rt_free_any;

   always_comb begin
      for (int s = 0; s < SETS; s++) begin
         valid_d[s] = valid_q[s];
         vptr_d[s]  = vptr_q[s];
      end
      if (flush_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            vptr_d[s]  = '0;
         end
      end else if (rt_we) begin
         valid_d[rt_idx][rt_way] = 1'b1;
         if (rt_advance && (WAYS > 1)) vptr_d[rt_idx] = vptr_q[rt_idx] + PTR_W'(1);
      end
   end

   // Lookup result and counters.  A lookup in a flush cycle reports a miss
   // and is left out of both counters.
   always_comb begin
      out_valid_d = is_branch_i && lk_hit && !flush_i;
      out_tgt_d   = out_valid_d ? lk_tgt : '0;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      if (out_valid_d && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
      if (is_branch_i && !lk_hit && !flush_i && (miss_cnt_q != 16'hFFFF))
         miss_cnt_d = miss_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            vptr_q[s]  <= '0;
         end
         out_valid_q <= 1'b0;
         out_tgt_q   <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= valid_d[s];
            vptr_q[s]  <= vptr_d[s];
         end
         out_valid_q <= out_valid_d;
         out_tgt_q   <= out_tgt_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Tag and target storage.  A write that races with reset is harmless
   // because reset clears the valid bit that would expose it.
   always_ff @(posedge clk) begin
      if (rt_we) begin
         tag_mem[rt_idx][rt_way] <= retire_pc_i;
         tgt_mem[rt_idx][rt_way] <= retire_tgt_pc_i;
      end
   end

   assign atb_valid_o  = out_valid_q;
   assign atb_tgt_pc_o = out_tgt_q;
   assign hit_cnt_o    = hit_cnt_q;
   assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_atb_assoc.sv
// ---------------------------------------------------------------------------
// tb_atb_assoc -- self-checking bench for atb_assoc (SETS=64, WAYS=4).
// The reference model stores each set as a list of {pc, target} entries and
// replaces entries in round-robin order once the set is full.
// ---------------------------------------------------------------------------
module tb_atb_assoc;

   localparam int SETS = 64;
   localparam int WAYS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        is_branch_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        retire_valid_i = 1'b0;
   logic [31:0] retire_pc_i = '0;
   logic [31:0] retire_tgt_pc_i = '0;
   logic        flush_i = 1'b0;
   logic        atb_valid_o;
   logic [31:0] atb_tgt_pc_o;
   logic [15:0] hit_cnt_o;
   logic [15:0] miss_cnt_o;

   int checks = 0;
   int errors = 0;

   atb_assoc #(.SETS(SETS), .WAYS(WAYS), .PC_W(32)) dut (
      .clk(clk), .reset(reset), .is_branch_i(is_branch_i), .pc_i(pc_i),
      .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
      .retire_tgt_pc_i(retire_tgt_pc_i), .flush_i(flush_i),
      .atb_valid_o(atb_valid_o), .atb_tgt_pc_o(atb_tgt_pc_o),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_used [SETS][WAYS];
   int unsigned m_pc   [SETS][WAYS];
   int unsigned m_tgt  [SETS][WAYS];
   int          m_next [SETS];   // next slot replaced once a set is full
   int          m_hits, m_misses;
   logic        exp_valid;
   logic [31:0] exp_tgt;

   function automatic void m_clear(input bit counters);
      for (int s = 0; s < SETS; s++) begin
         m_next[s] = 0;
         for (int w = 0; w < WAYS; w++) m_used[s][w] = 0;
      end
      if (counters) begin
         m_hits = 0; m_misses = 0; exp_valid = 0; exp_tgt = 0;
      end
   endfunction

   function automatic void m_lookup(input int unsigned pc, output bit hit, output int unsigned tgt);
      int s = int'(pc % SETS);
      hit = 0; tgt = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_used[s][w] && m_pc[s][w] == pc) begin hit = 1; tgt = m_tgt[s][w]; end
   endfunction

   function automatic void m_retire(input int unsigned pc, input int unsigned tgt);
      int s = int'(pc % SETS);
      for (int w = 0; w < WAYS; w++)
         if (m_used[s][w] && m_pc[s][w] == pc) begin m_tgt[s][w] = tgt; return; end
      for (int w = 0; w < WAYS; w++)
         if (!m_used[s][w]) begin
            m_used[s][w] = 1; m_pc[s][w] = pc; m_tgt[s][w] = tgt; return;
         end
      m_pc[s][m_next[s]] = pc; m_tgt[s][m_next[s]] = tgt;
      m_next[s] = (m_next[s] + 1) % WAYS;
   endfunction

   // Drive one cycle, advance the model, and sample 1 ns after the edge.
   task automatic drive(input bit br, input int unsigned pc, input bit rv,
                        input int unsigned rpc, input int unsigned rtgt,
                        input bit fl, input bit verbose);
      bit hit; int unsigned tgt;
      @(negedge clk);
      is_branch_i = br; pc_i = pc; retire_valid_i = rv; retire_pc_i = rpc;
      retire_tgt_pc_i = rtgt; flush_i = fl;
      m_lookup(pc, hit, tgt);
      exp_valid = 0; exp_tgt = 0;
      if (br && !fl) begin
         if (hit) begin
            exp_valid = 1; exp_tgt = tgt;
            if (m_hits < 65535) m_hits++;
         end else if (m_misses < 65535) m_misses++;
      end
      if (fl) m_clear(0);
      else if (rv) m_retire(rpc, rtgt);
      @(posedge clk); #1;
      is_branch_i = 0; retire_valid_i = 0; flush_i = 0;
      if (verbose)
         $display("txn br=%0b pc=%h rv=%0b rpc=%h rtgt=%h fl=%0b -> valid=%0b tgt=%h hit=%0d miss=%0d",
                  br, pc, rv, rpc, rtgt, fl, atb_valid_o, atb_tgt_pc_o, hit_cnt_o, miss_cnt_o);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      m_clear(1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (atb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", atb_valid_o); end
      checks++; if (atb_tgt_pc_o !== 32'h0) begin errors++; $display("FAIL reset_tgt: got %h want 0", atb_tgt_pc_o); end
      checks++; if (hit_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt_o); end
      checks++; if (miss_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt_o); end
      @(negedge clk);
      reset = 0;
      m_clear(1);
   endtask

   task automatic test_basic();
      do_reset();
      drive(0, 0, 1, 32'h100, 32'h2000, 0, 1);
      drive(1, 32'h100, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", atb_valid_o); end
      checks++; if (atb_tgt_pc_o !== 32'h2000) begin errors++; $display("FAIL basic_tgt: got %h want 00002000", atb_tgt_pc_o); end
      checks++; if (hit_cnt_o !== 16'd1) begin errors++; $display("FAIL basic_hit_cnt: got %0d want 1", hit_cnt_o); end
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b0 || atb_tgt_pc_o !== 32'h0) begin
         errors++; $display("FAIL basic_idle: got valid=%0b tgt=%h want 0/0", atb_valid_o, atb_tgt_pc_o); end
   endtask

   task automatic test_eviction();
      int unsigned pcs [4] = '{32'h000, 32'h040, 32'h080, 32'h0C0};
      do_reset();
      foreach (pcs[i]) drive(0, 0, 1, pcs[i], 32'hA000 + pcs[i], 0, 1);
      foreach (pcs[i]) begin
         drive(1, pcs[i], 0, 0, 0, 0, 1);
         checks++; if (atb_valid_o !== 1'b1 || atb_tgt_pc_o !== 32'hA000 + pcs[i]) begin
            errors++; $display("FAIL evict_fill_hit%0d: got valid=%0b tgt=%h want 1/%h", i, atb_valid_o, atb_tgt_pc_o, 32'hA000 + pcs[i]); end
      end
      drive(0, 0, 1, 32'h100, 32'hB100, 0, 1);
      drive(1, 32'h000, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b0) begin errors++; $display("FAIL evict_victim_miss: got %0b want 0", atb_valid_o); end
      drive(1, 32'h100, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1 || atb_tgt_pc_o !== 32'hB100) begin
         errors++; $display("FAIL evict_new_hit: got valid=%0b tgt=%h want 1/0000b100", atb_valid_o, atb_tgt_pc_o); end
      // The pointer has moved to way 1, so the next replacement evicts 0x040.
      drive(0, 0, 1, 32'h140, 32'hB140, 0, 1);
      drive(1, 32'h040, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b0) begin errors++; $display("FAIL evict_rr_second: got %0b want 0", atb_valid_o); end
      drive(1, 32'h080, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1) begin errors++; $display("FAIL evict_rr_keep: got %0b want 1", atb_valid_o); end
   endtask

   task automatic test_update();
      do_reset();
      drive(0, 0, 1, 32'h100, 32'h2000, 0, 1);
      drive(0, 0, 1, 32'h100, 32'h3000, 0, 1);
      drive(1, 32'h100, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1 || atb_tgt_pc_o !== 32'h3000) begin
         errors++; $display("FAIL update_tgt: got valid=%0b tgt=%h want 1/00003000", atb_valid_o, atb_tgt_pc_o); end
      // Three new PCs should fit without evicting 0x100, which shows the
      // update did not consume another way.
      drive(0, 0, 1, 32'h140, 32'h1, 0, 1);
      drive(0, 0, 1, 32'h180, 32'h2, 0, 1);
      drive(0, 0, 1, 32'h1C0, 32'h3, 0, 1);
      drive(1, 32'h100, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1 || atb_tgt_pc_o !== 32'h3000) begin
         errors++; $display("FAIL update_no_dup: got valid=%0b tgt=%h want 1/00003000", atb_valid_o, atb_tgt_pc_o); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      drive(1, 32'h200, 1, 32'h200, 32'h4444, 0, 1);
      checks++; if (atb_valid_o !== 1'b0 || miss_cnt_o !== 16'd1) begin
         errors++; $display("FAIL rbw_miss: got valid=%0b miss=%0d want 0/1", atb_valid_o, miss_cnt_o); end
      drive(1, 32'h200, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1 || atb_tgt_pc_o !== 32'h4444) begin
         errors++; $display("FAIL rbw_next_hit: got valid=%0b tgt=%h want 1/00004444", atb_valid_o, atb_tgt_pc_o); end
   endtask

   task automatic test_flush();
      int unsigned pcs [5] = '{32'h301, 32'h342, 32'h003, 32'h044, 32'h305};
      int unsigned h0, m0;
      do_reset();
      foreach (pcs[i]) drive(0, 0, 1, pcs[i], 32'hC000 + i, 0, 1);
      foreach (pcs[i]) drive(1, pcs[i], 0, 0, 0, 0, 1);
      drive(1, 32'h777, 0, 0, 0, 0, 1);
      h0 = 5; m0 = 1;
      drive(0, 0, 1, 32'h300, 32'hD300, 1, 1);
      checks++; if (hit_cnt_o !== 16'(h0) || miss_cnt_o !== 16'(m0)) begin
         errors++; $display("FAIL flush_counters: got hit=%0d miss=%0d want %0d/%0d", hit_cnt_o, miss_cnt_o, h0, m0); end
      foreach (pcs[i]) begin
         drive(1, pcs[i], 0, 0, 0, 0, 1);
         checks++; if (atb_valid_o !== 1'b0 || atb_tgt_pc_o !== 32'h0) begin
            errors++; $display("FAIL flush_miss%0d: got valid=%0b tgt=%h want 0/0", i, atb_valid_o, atb_tgt_pc_o); end
      end
      drive(1, 32'h300, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_retire_dropped: got %0b want 0", atb_valid_o); end
      checks++; if (hit_cnt_o !== 16'(h0) || miss_cnt_o !== 16'(m0 + 6)) begin
         errors++; $display("FAIL flush_counters_after: got hit=%0d miss=%0d want %0d/%0d", hit_cnt_o, miss_cnt_o, h0, m0 + 6); end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int unsigned lpc = $urandom_range(0, 7) * 64 + $urandom_range(0, 3);
         int unsigned rpc = $urandom_range(0, 7) * 64 + $urandom_range(0, 3);
         bit fl = ($urandom_range(0, 99) == 0);
         bit br = fl ? 1'b0 : 1'($urandom_range(0, 1));
         drive(br, lpc, 1'($urandom_range(0, 1)), rpc, $urandom, fl, 0);
         checks++;
         if (atb_valid_o !== exp_valid || atb_tgt_pc_o !== exp_tgt ||
             hit_cnt_o !== 16'(m_hits) || miss_cnt_o !== 16'(m_misses)) begin
            errors++; bad++;
            if (bad <= 10)
               $display("FAIL random_cycle%0d: got v=%0b t=%h h=%0d m=%0d want v=%0b t=%h h=%0d m=%0d",
                        n, atb_valid_o, atb_tgt_pc_o, hit_cnt_o, miss_cnt_o,
                        exp_valid, exp_tgt, m_hits, m_misses);
         end
      end
      $display("txn random: 3000 cycles, hits=%0d misses=%0d", m_hits, m_misses);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int n = 0; n < 65540; n++) drive(1, n * 4, 0, 0, 0, 0, 0);
      checks++; if (miss_cnt_o !== 16'hFFFF || hit_cnt_o !== 16'h0) begin
         errors++; $display("FAIL sat_miss: got miss=%h hit=%0d want ffff/0", miss_cnt_o, hit_cnt_o); end
      drive(0, 0, 1, 32'h10, 32'h5555, 0, 1);
      drive(1, 32'h10, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b1 || hit_cnt_o !== 16'd1 || miss_cnt_o !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold: got valid=%0b hit=%0d miss=%h want 1/1/ffff", atb_valid_o, hit_cnt_o, miss_cnt_o); end
      // Assert reset between edges; outputs must clear before the next edge.
      #2 reset = 1;
      #1;
      checks++; if (atb_valid_o !== 1'b0 || atb_tgt_pc_o !== 32'h0 || hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0) begin
         errors++; $display("FAIL async_reset: got v=%0b t=%h h=%0d m=%0d want all 0", atb_valid_o, atb_tgt_pc_o, hit_cnt_o, miss_cnt_o); end
      @(negedge clk);
      reset = 0;
      m_clear(1);
      drive(1, 32'h10, 0, 0, 0, 0, 1);
      checks++; if (atb_valid_o !== 1'b0 || miss_cnt_o !== 16'd1) begin
         errors++; $display("FAIL post_reset_miss: got valid=%0b miss=%0d want 0/1", atb_valid_o, miss_cnt_o); end
   endtask

   initial begin
      m_clear(1);
      test_reset();
      test_basic();
      test_eviction();
      test_update();
      test_same_cycle();
      test_flush();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
